// File: rtl/led_blink_tx.sv
// ---------------------------------------------------------------------------
// led_blink_tx
//
// Transmit side of the operator interface. It turns a requested count N into
// N visible blinks on one active-low LED, then holds the LED dark for an
// inter-message gap. Typical payloads are error numbers, press counts or mode
// indices reported back to the operator.
//
// Timing of one message (accept edge = cycle 0, N >= 1):
//   N x ON_CYCLES lit, (N-1) x OFF_CYCLES dark between blinks,
//   GAP_CYCLES dark, then a one-cycle o_done in the first IDLE cycle.
//   Total cycles from accept edge to o_done: N*ON + (N-1)*OFF + GAP + 1.
// A request with N == 0 produces no blink, only the gap, so message spacing
// stays uniform.
//
// Ports:
//   i_clk    in   system clock
//   i_rst_n  in   asynchronous active-low reset
//   i_valid  in   request valid; the requester holds it until accepted
//   i_count  in   number of blinks requested, sampled only at the accept edge
//   o_ready  out  high only in IDLE (combinational from state)
//   o_led    out  LED drive, active-low (0 = lit), registered
//   o_busy   out  high from the cycle after acceptance until back in IDLE
//   o_done   out  one-cycle pulse in the first IDLE cycle after a message
// ---------------------------------------------------------------------------
module led_blink_tx #(
    parameter int ON_CYCLES  = 13500000,  // clocks lit per blink, >= 1
    parameter int OFF_CYCLES = 13500000,  // clocks dark between blinks, >= 1
    parameter int GAP_CYCLES = 27000000,  // clocks dark after last blink, >= 1
    parameter int CNT_W      = 4          // width of the blink-count request
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_valid,
    input  logic [CNT_W-1:0] i_count,
    output logic             o_ready,
    output logic             o_led,
    output logic             o_busy,
    output logic             o_done
);

    // One shared down-counter times every phase, so it is sized for the
    // longest of the three durations plus one bit of headroom.
    localparam int MAX_ON_OFF = (ON_CYCLES > OFF_CYCLES) ? ON_CYCLES : OFF_CYCLES;
    localparam int MAX_CYC    = (MAX_ON_OFF > GAP_CYCLES) ? MAX_ON_OFF : GAP_CYCLES;
    localparam int TMR_W      = $clog2(MAX_CYC) + 1;

    localparam logic [TMR_W-1:0] ON_LOAD  = TMR_W'(ON_CYCLES);
    localparam logic [TMR_W-1:0] OFF_LOAD = TMR_W'(OFF_CYCLES);
    localparam logic [TMR_W-1:0] GAP_LOAD = TMR_W'(GAP_CYCLES);
    localparam logic [TMR_W-1:0] TMR_ONE  = TMR_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ON   = 2'd1,
        S_OFF  = 2'd2,
        S_GAP  = 2'd3
    } state_t;

    state_t             state;
    logic [TMR_W-1:0]   timer;      // cycles left in the current phase
    logic [CNT_W-1:0]   remaining;  // blinks left, including the current one
    logic               timer_last;

    // The timer is loaded with the full phase length on entry and the phase
    // ends on the edge where it reads 1, so each phase lasts exactly its
    // configured number of cycles.
    assign timer_last = (timer == TMR_ONE);

    // Ready is purely a function of state so the requester sees it without
    // an extra cycle of latency; IDLE is the only state that accepts.
    assign o_ready = (state == S_IDLE);

    // NOTE: all state and outputs update with non-blocking assignments in a
    // single clocked process; the reset branch is asynchronous so asserting
    // i_rst_n mid-sequence darkens the LED without waiting for a clock edge.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state     <= S_IDLE;
            timer     <= '0;
            remaining <= '0;
            o_led     <= 1'b1;
            o_busy    <= 1'b0;
            o_done    <= 1'b0;
        end else begin
            // o_done is a strobe: cleared every cycle unless the GAP->IDLE
            // transition below raises it.
            o_done <= 1'b0;

            case (state)
                S_IDLE: begin
                    if (i_valid) begin
                        o_busy    <= 1'b1;
                        remaining <= i_count;
                        if (i_count != '0) begin
                            state <= S_ON;
                            timer <= ON_LOAD;
                            o_led <= 1'b0;
                        end else begin
                            // Zero blinks still costs one gap so that the
                            // operator sees consistent spacing.
                            state <= S_GAP;
                            timer <= GAP_LOAD;
                            o_led <= 1'b1;
                        end
                    end
                end

                S_ON: begin
                    if (timer_last) begin
                        o_led <= 1'b1;
                        if (remaining > CNT_ONE) begin
                            state     <= S_OFF;
                            timer     <= OFF_LOAD;
                            remaining <= remaining - CNT_ONE;
                        end else begin
                            // Last blink: the remaining counter is left at 1
                            // and never wraps through zero.
                            state <= S_GAP;
                            timer <= GAP_LOAD;
                        end
                    end else begin
                        timer <= timer - TMR_ONE;
                    end
                end

                S_OFF: begin
                    if (timer_last) begin
                        state <= S_ON;
                        timer <= ON_LOAD;
                        o_led <= 1'b0;
                    end else begin
                        timer <= timer - TMR_ONE;
                    end
                end

                S_GAP: begin
                    if (timer_last) begin
                        state  <= S_IDLE;
                        o_busy <= 1'b0;
                        o_done <= 1'b1;
                        o_led  <= 1'b1;
                    end else begin
                        timer <= timer - TMR_ONE;
                    end
                end

                default: begin
                    state  <= S_IDLE;
                    o_led  <= 1'b1;
                    o_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_led_blink_tx.sv
// ---------------------------------------------------------------------------
// tb_led_blink_tx
//
// Scoreboard bench for led_blink_tx with ON=3, OFF=2, GAP=4, CNT_W=4.
// When a request is accepted, the expected per-cycle values of o_led, o_busy,
// o_done and o_ready for the whole message are pushed to a queue; a monitor
// on the falling clock edge pops one entry per cycle and compares.
// ---------------------------------------------------------------------------
module tb_led_blink_tx;

    localparam int ON_C  = 3;
    localparam int OFF_C = 2;
    localparam int GAP_C = 4;
    localparam int CW    = 4;

    logic          i_clk;
    logic          i_rst_n;
    logic          i_valid;
    logic [CW-1:0] i_count;
    logic          o_ready;
    logic          o_led;
    logic          o_busy;
    logic          o_done;

    typedef struct {
        logic led;
        logic busy;
        logic done;
        logic ready;
    } exp_t;

    exp_t exp_q[$];

    int checks   = 0;
    int failures = 0;
    int pulses   = 0;
    logic prev_led = 1'b1;

    led_blink_tx #(
        .ON_CYCLES (ON_C),
        .OFF_CYCLES(OFF_C),
        .GAP_CYCLES(GAP_C),
        .CNT_W     (CW)
    ) dut (
        .i_clk  (i_clk),
        .i_rst_n(i_rst_n),
        .i_valid(i_valid),
        .i_count(i_count),
        .o_ready(o_ready),
        .o_led  (o_led),
        .o_busy (o_busy),
        .o_done (o_done)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, got, exp);
        end
    endtask

    task automatic push_cycle(input logic led, input logic busy, input logic done, input logic ready);
        exp_t e;
        e.led   = led;
        e.busy  = busy;
        e.done  = done;
        e.ready = ready;
        exp_q.push_back(e);
    endtask

    // Expected outputs for cycles 1..T after an accept edge with count n.
    task automatic push_seq(input int n);
        for (int b = 0; b < n; b++) begin
            repeat (ON_C) push_cycle(1'b0, 1'b1, 1'b0, 1'b0);
            if (b != n - 1)
                repeat (OFF_C) push_cycle(1'b1, 1'b1, 1'b0, 1'b0);
        end
        repeat (GAP_C) push_cycle(1'b1, 1'b1, 1'b0, 1'b0);
        push_cycle(1'b1, 1'b0, 1'b1, 1'b1);
    endtask

    // Monitor: compare one expected cycle per falling edge, count LED pulses.
    always @(negedge i_clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            check("led",   32'(o_led),   32'(e.led));
            check("busy",  32'(o_busy),  32'(e.busy));
            check("done",  32'(o_done),  32'(e.done));
            check("ready", 32'(o_ready), 32'(e.ready));
        end
        if (prev_led && !o_led) pulses++;
        prev_led = o_led;
    end

    // Called at posedge+1; waits (bounded) until the block is idle.
    task automatic wait_ready();
        int k;
        k = 0;
        while (!o_ready && k < 200) begin
            @(posedge i_clk);
            #1;
            k++;
        end
        check("ready_wait", 32'(o_ready), 32'd1);
    endtask

    task automatic send(input int n);
        wait_ready();
        i_valid = 1'b1;
        i_count = CW'(n);
        @(posedge i_clk);
        push_seq(n);
        #1;
        i_valid = 1'b0;
    endtask

    task automatic wait_drain(input int budget);
        int k;
        k = 0;
        while (exp_q.size() != 0 && k < budget) begin
            @(posedge i_clk);
            k++;
        end
        #1;
        check("drain", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        int done_seen;

        // Reset held with a pending request.
        i_rst_n = 1'b0;
        i_valid = 1'b1;
        i_count = 4'd1;
        repeat (3) @(negedge i_clk);
        check("rst_led",   32'(o_led),   32'd1);
        check("rst_ready", 32'(o_ready), 32'd1);
        check("rst_busy",  32'(o_busy),  32'd0);
        check("rst_done",  32'(o_done),  32'd0);

        // Release: the held request is accepted on the first edge.
        @(posedge i_clk);
        #1;
        i_rst_n = 1'b1;
        pulses  = 0;
        @(posedge i_clk);
        push_seq(1);
        #1;
        i_valid = 1'b0;
        wait_drain(50);
        check("pulses_first", 32'(pulses), 32'd1);

        // N=2 with a rejected request at cycle 7.
        pulses = 0;
        send(2);
        repeat (6) @(posedge i_clk);
        #1;
        i_valid = 1'b1;
        i_count = 4'd5;
        @(posedge i_clk);
        #1;
        i_valid = 1'b0;
        wait_drain(50);
        check("pulses_n2", 32'(pulses), 32'd2);

        // N=0: gap only.
        pulses = 0;
        send(0);
        wait_drain(50);
        check("pulses_n0", 32'(pulses), 32'd0);

        // Back-to-back N=1 with i_valid held through the re-accept at cycle 8.
        wait_ready();
        pulses  = 0;
        i_valid = 1'b1;
        i_count = 4'd1;
        @(posedge i_clk);
        push_seq(1);
        push_seq(1);
        #1;
        repeat (8) @(posedge i_clk);
        #1;
        i_valid = 1'b0;
        wait_drain(50);
        check("pulses_b2b", 32'(pulses), 32'd2);

        // Maximum count.
        pulses = 0;
        send(15);
        wait_drain(200);
        check("pulses_n15", 32'(pulses), 32'd15);

        // Asynchronous reset in the middle of an ON phase.
        send(3);
        #2;
        exp_q.delete();
        i_rst_n = 1'b0;
        #1;
        check("arst_led",   32'(o_led),   32'd1);
        check("arst_busy",  32'(o_busy),  32'd0);
        check("arst_ready", 32'(o_ready), 32'd1);
        check("arst_done",  32'(o_done),  32'd0);
        repeat (2) @(posedge i_clk);
        #1;
        i_rst_n   = 1'b1;
        done_seen = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge i_clk);
            if (o_done || !o_led || o_busy || !o_ready) done_seen++;
        end
        check("arst_idle_after", 32'(done_seen), 32'd0);

        // Block still works after the mid-message reset.
        @(posedge i_clk);
        #1;
        pulses = 0;
        send(1);
        wait_drain(50);
        check("pulses_post_rst", 32'(pulses), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Absolute time limit in case a wait loop is broken.
    initial begin
        #200000;
        $display("FAIL timeout at %0t", $time);
        $fatal(1, "time limit reached");
    end

endmodule
